// File: rtl/gpio_uart_tx.sv
// Buffers bytes written to the data-memory GPIO port and serialises them as 8N1 UART frames.
// Latency: byte accepted at edge N into an idle, empty block drives the start bit from edge N+1.
// Backpressure: none towards the CPU; bytes arriving while the FIFO is full are dropped and flagged.
//
// Ports:
//   clk, rst         system clock, asynchronous active-high reset
//   gpio_data/valid  one byte per cycle while gpio_valid is high
//   tx               UART line, idle high, driven straight from a flop
//   busy             FIFO non-empty or a frame in progress
//   fifo_full        FIFO holds FIFO_DEPTH entries
//   fifo_count       current FIFO occupancy
//   overflow         sticky: at least one byte was dropped since reset
module gpio_uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [7:0]                  gpio_data,
    input  logic                        gpio_valid,
    output logic                        tx,
    output logic                        busy,
    output logic                        fifo_full,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    state_t        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;

    logic full, pop, push_ok, baud_end;

    // FIFO bookkeeping. A pop only happens from IDLE with data present, so a
    // push into a full FIFO is still accepted when it lands on the pop edge.
    always_comb begin
        full     = (count_q == DEPTH_C);
        pop      = (state_q == IDLE) && (count_q != '0);
        push_ok  = gpio_valid && (!full || pop);
        wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        ovf_d    = ovf_q | (gpio_valid & ~push_ok);
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage has no reset: only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= gpio_data;
        end
    end

    // Serialiser. tx_d is computed one cycle ahead so the line comes from a flop.
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        baud_end = (baud_q == BAUD_LAST);
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (pop) begin
                    shift_d = mem_q[rd_ptr_q];
                    baud_d  = '0;
                    bit_d   = '0;
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    tx_d    = shift_q[0];
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = IDLE;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
        end
    end

    assign tx         = tx_q;
    assign busy       = (state_q != IDLE) || (count_q != '0);
    assign fifo_full  = full;
    assign fifo_count = count_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_gpio_uart_tx.sv
// Bench for gpio_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// A UART monitor decodes tx and compares each frame with a byte scoreboard.
// Per-cycle FIFO expectations come from a vector table plus hand-written sequences.
module tb_gpio_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] gpio_data = 8'h00;
    logic       gpio_valid = 1'b0;
    logic       tx, busy, fifo_full, overflow;
    logic [2:0] fifo_count;

    gpio_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .gpio_data  (gpio_data),
        .gpio_valid (gpio_valid),
        .tx         (tx),
        .busy       (busy),
        .fifo_full  (fifo_full),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] sb_q[$];
    int         starts[$];
    int         cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive inputs, then advance to just after the next rising edge.
    task automatic step(input logic v, input logic [7:0] d);
        gpio_valid = v;
        gpio_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        sb_q.push_back(d);
        step(1'b1, d);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            step(1'b0, 8'h00);
            n++;
        end
        check("idle_timeout", busy, 0);
    endtask

    // UART monitor: samples each bit in the middle of its CPB-cycle window.
    bit         mon_act = 0;
    int         mon_t   = 0;
    logic [7:0] mon_sh  = 8'h00;
    logic [7:0] mon_exp;
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                mon_act = 0;
            end else if (!mon_act) begin
                if (tx === 1'b0) begin
                    mon_act = 1;
                    mon_t   = 0;
                    starts.push_back(cyc);
                end
            end else begin
                mon_t++;
                if (mon_t == CPB/2) begin
                    check("start_bit", tx, 0);
                end else if (mon_t % CPB == CPB/2 && mon_t < 9*CPB) begin
                    mon_sh[mon_t/CPB - 1] = tx;
                end else if (mon_t == 9*CPB + CPB/2) begin
                    check("stop_bit", tx, 1);
                    if (sb_q.size() == 0) begin
                        check("unexpected_frame", {24'h0, mon_sh}, 32'hFFFF_FFFF);
                    end else begin
                        mon_exp = sb_q.pop_front();
                        check("frame_data", mon_sh, mon_exp);
                    end
                    mon_act = 0;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic       v;
        logic [7:0] d;
        bit         acc;
        logic [2:0] cnt;
        logic       full;
        logic       ovf;
        logic       busy;
    } vec_t;

    initial begin
        vec_t       vt[7];
        logic       exp_tx[40];
        logic [7:0] b;
        int         k;

        // Expected line for a single 0xA5 frame, one entry per cycle.
        b = 8'hA5;
        for (int i = 0; i < 40; i++) begin
            k = i / CPB;
            exp_tx[i] = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
        end
        // Six back-to-back pushes from idle: first goes on the wire, four queue, one drops.
        vt[0] = '{1'b1, 8'hB0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b1};
        vt[1] = '{1'b1, 8'hB1, 1'b1, 3'd1, 1'b0, 1'b0, 1'b1};
        vt[2] = '{1'b1, 8'hB2, 1'b1, 3'd2, 1'b0, 1'b0, 1'b1};
        vt[3] = '{1'b1, 8'hB3, 1'b1, 3'd3, 1'b0, 1'b0, 1'b1};
        vt[4] = '{1'b1, 8'hB4, 1'b1, 3'd4, 1'b1, 1'b0, 1'b1};
        vt[5] = '{1'b1, 8'hB5, 1'b0, 3'd4, 1'b1, 1'b1, 1'b1};
        vt[6] = '{1'b0, 8'h00, 1'b0, 3'd4, 1'b1, 1'b1, 1'b1};

        // Reset values
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_full", fifo_full, 0);
        check("rst_count", fifo_count, 0);
        check("rst_ovf", overflow, 0);
        rst = 1'b0;
        step(1'b0, 8'h00);
        step(1'b0, 8'h00);

        // Single frame 0xA5, cycle-exact
        push(8'hA5);
        check("t1_count_push", fifo_count, 1);
        check("t1_tx_push", tx, 1);
        check("t1_busy_push", busy, 1);
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 8'h00);
            check("t1_tx", tx, exp_tx[i]);
            if (i == 0) check("t1_count_pop", fifo_count, 0);
        end
        check("t1_busy_stop_end", busy, 1);
        step(1'b0, 8'h00);
        check("t1_busy_drop", busy, 0);
        check("t1_tx_idle", tx, 1);
        check("t1_ovf", overflow, 0);
        check("t1_sb_empty", sb_q.size(), 0);

        // Burst of three, frame spacing
        starts.delete();
        push(8'h01);
        check("t2_count0", fifo_count, 1);
        push(8'h02);
        check("t2_count1", fifo_count, 1);
        push(8'h03);
        check("t2_count2", fifo_count, 2);
        step(1'b0, 8'h00);
        wait_idle(200);
        check("t2_frames", starts.size(), 3);
        if (starts.size() == 3) begin
            check("t2_gap01", starts[1] - starts[0], 10*CPB + 1);
            check("t2_gap12", starts[2] - starts[1], 10*CPB + 1);
        end
        check("t2_sb_empty", sb_q.size(), 0);

        // Overflow burst from the vector table
        for (int i = 0; i < 7; i++) begin
            if (vt[i].acc) sb_q.push_back(vt[i].d);
            step(vt[i].v, vt[i].d);
            check($sformatf("t3_count_%0d", i), fifo_count, vt[i].cnt);
            check($sformatf("t3_full_%0d", i), fifo_full, vt[i].full);
            check($sformatf("t3_ovf_%0d", i), overflow, vt[i].ovf);
            check($sformatf("t3_busy_%0d", i), busy, vt[i].busy);
        end
        // First frame started one edge after vt[0]; the next pop lands 41 edges later.
        for (int i = 7; i < 42; i++) step(1'b0, 8'h00);
        check("t4_count_pre", fifo_count, 4);
        check("t4_tx_pre", tx, 1);
        push(8'hB6);
        check("t4_count_pop_push", fifo_count, 4);
        check("t4_full_pop_push", fifo_full, 1);
        check("t4_ovf_pop_push", overflow, 1);
        check("t4_tx_start", tx, 0);
        step(1'b0, 8'h00);
        wait_idle(6*(10*CPB + 1) + 20);
        check("t3_ovf_sticky", overflow, 1);
        check("t3_count_drained", fifo_count, 0);
        check("t3_full_drained", fifo_full, 0);
        check("t3_sb_empty", sb_q.size(), 0);

        // Reset in the middle of DATA
        push(8'hFF);
        push(8'h77);
        for (int i = 0; i < 10; i++) step(1'b0, 8'h00);
        #2;
        rst = 1'b1;
        sb_q.delete();
        #1;
        check("t5_tx", tx, 1);
        check("t5_count", fifo_count, 0);
        check("t5_busy", busy, 0);
        check("t5_ovf", overflow, 0);
        check("t5_full", fifo_full, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1'b0, 8'h00);
        push(8'h3C);
        step(1'b0, 8'h00);
        wait_idle(100);
        check("t5_sb_empty", sb_q.size(), 0);
        check("t5_ovf_after", overflow, 0);

        // Data toggling with valid low
        for (int i = 0; i < 100; i++) begin
            step(1'b0, 8'($urandom));
            check("t6_tx", tx, 1);
            check("t6_count", fifo_count, 0);
            check("t6_busy", busy, 0);
        end
        check("final_sb_empty", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
